// File: rtl/median_rank_stream.sv
// 3x3 rank filter (median / min / max / bypass) over one raster frame, with two internal
// line buffers, an end-of-frame flush and a four-stage output pipeline.
module median_rank_stream #(
    parameter int DATA_W = 8,
    parameter int COLS   = 30,
    parameter int ROWS   = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        mode_i,
    input  logic              border_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int TOTAL = ROWS * COLS;
    localparam int SW    = $clog2(TOTAL + COLS + 1);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);

    localparam logic [SW-1:0] LAST_IN    = SW'(TOTAL - 1);
    localparam logic [SW-1:0] LAST_SLOT  = SW'(TOTAL + COLS);
    localparam logic [SW-1:0] FIRST_EMIT = SW'(COLS + 1);
    localparam logic [CW-1:0] COL_MAX    = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX    = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t          state;
    logic [SW-1:0]   slot_cnt;
    logic [CW-1:0]   in_col;
    logic [CW-1:0]   out_col;
    logic [RW-1:0]   out_row;
    logic [1:0]      mode_q;
    logic            border_q;

    // lb_a holds the previous input row, lb_b the row before that.
    pix_t            lb_a [COLS];
    pix_t            lb_b [COLS];
    pix_t            win  [3][3];

    logic            s1_valid, s1_last, s1_edge, s1_bpass;
    logic [1:0]      s1_mode;
    logic            s2_valid, s2_last, s2_edge, s2_bpass;
    logic [1:0]      s2_mode;
    pix_t            s2_ctr;
    pix_t            s2_lo [3];
    pix_t            s2_mid[3];
    pix_t            s2_hi [3];
    logic            s3_valid, s3_last, s3_edge, s3_bpass;
    logic [1:0]      s3_mode;
    pix_t            s3_ctr, s3_min, s3_max, s3_a, s3_b, s3_c;

    logic            accept;
    logic            slot;
    logic            emit;
    pix_t            new_pix;
    pix_t            tap_a;
    pix_t            tap_b;
    pix_t            result;

    // A slot is one shift of the window: an accepted pixel or a flush cycle.
    assign accept  = valid_i && (state != FLUSH);
    assign slot    = accept || (state == FLUSH);
    assign emit    = slot && (slot_cnt >= FIRST_EMIT);
    assign new_pix = accept ? data_i : '0;
    assign tap_a   = lb_a[in_col];
    assign tap_b   = lb_b[in_col];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        result = s3_ctr;
        if (s3_mode != 2'd0) begin
            if (s3_edge) begin
                result = s3_bpass ? s3_ctr : '0;
            end else begin
                case (s3_mode)
                    2'd1:    result = med3(s3_a, s3_b, s3_c);
                    2'd2:    result = s3_min;
                    default: result = s3_max;
                endcase
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            slot_cnt   <= '0;
            in_col     <= '0;
            out_col    <= '0;
            out_row    <= '0;
            mode_q     <= 2'd0;
            border_q   <= 1'b0;
            busy_o     <= 1'b0;
            overflow_o <= 1'b0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            valid_o    <= 1'b0;
            data_o     <= '0;
            last_o     <= 1'b0;
        end else begin
            if (valid_i && state == FLUSH) overflow_o <= 1'b1;

            case (state)
                IDLE: begin
                    if (valid_i) begin
                        mode_q   <= mode_i;
                        border_q <= border_i;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (valid_i && slot_cnt == LAST_IN) begin
                        state  <= FLUSH;
                        busy_o <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (slot_cnt == LAST_SLOT) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (slot) begin
                if (slot_cnt == LAST_SLOT) begin
                    slot_cnt <= '0;
                    in_col   <= '0;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                    in_col   <= (in_col == COL_MAX) ? '0 : in_col + 1'b1;
                end
            end

            if (emit) begin
                if (out_col == COL_MAX) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_MAX) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end

            s1_valid <= emit;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            valid_o  <= s3_valid;
            last_o   <= s3_valid && s3_last;
            if (s3_valid) data_o <= result;
        end
    end

    // NOTE: line buffers and pipeline data carry no reset; valid tags alone qualify them.
    always_ff @(posedge clk) begin
        if (slot) begin
            lb_a[in_col] <= new_pix;
            lb_b[in_col] <= tap_a;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= tap_b;
            win[1][2] <= tap_a;
            win[2][2] <= new_pix;
        end

        if (emit) begin
            s1_last  <= (out_row == ROW_MAX) && (out_col == COL_MAX);
            s1_edge  <= (out_row == '0) || (out_row == ROW_MAX) ||
                        (out_col == '0) || (out_col == COL_MAX);
            s1_bpass <= border_q;
            s1_mode  <= mode_q;
        end

        // Row sort: each window row ordered into low / mid / high.
        for (int i = 0; i < 3; i++) begin
            s2_lo[i]  <= min3(win[i][0], win[i][1], win[i][2]);
            s2_mid[i] <= med3(win[i][0], win[i][1], win[i][2]);
            s2_hi[i]  <= max3(win[i][0], win[i][1], win[i][2]);
        end
        s2_ctr   <= win[1][1];
        s2_last  <= s1_last;
        s2_edge  <= s1_edge;
        s2_bpass <= s1_bpass;
        s2_mode  <= s1_mode;

        // Column sort: the median lies among max-of-lows, mid-of-mids, min-of-highs.
        s3_min   <= min3(s2_lo[0], s2_lo[1], s2_lo[2]);
        s3_max   <= max3(s2_hi[0], s2_hi[1], s2_hi[2]);
        s3_a     <= max3(s2_lo[0], s2_lo[1], s2_lo[2]);
        s3_b     <= med3(s2_mid[0], s2_mid[1], s2_mid[2]);
        s3_c     <= min3(s2_hi[0], s2_hi[1], s2_hi[2]);
        s3_ctr   <= s2_ctr;
        s3_last  <= s2_last;
        s3_edge  <= s2_edge;
        s3_bpass <= s2_bpass;
        s3_mode  <= s2_mode;
    end

endmodule

// File: tb/tb_median_rank_stream.sv
// Scoreboard bench for median_rank_stream on a 5x5 frame: driver pushes expected pixels,
// a forked monitor pops and compares whenever valid_o is high.
module tb_median_rank_stream;

    localparam int DW = 8;
    localparam int C  = 5;
    localparam int R  = 5;
    localparam int N  = R * C;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic [1:0]    mode_i;
    logic          border_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          busy_o;
    logic          overflow_o;

    exp_t          sb[$];
    logic [DW-1:0] pix[N];
    logic [DW-1:0] cap[N];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            out_cnt = 0;
    int            busy_cnt = 0;
    int            first_cyc = -1;
    int            acc6 = 0;

    median_rank_stream #(.DATA_W(DW), .COLS(C), .ROWS(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .mode_i     (mode_i),
        .border_i   (border_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .last_o     (last_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Straightforward reference: gather the 3x3 neighbourhood and fully sort it.
    function automatic logic [DW-1:0] ref_out(input int k, input int mode, input int bord);
        int r, c, n, t;
        int w[9];
        r = k / C;
        c = k % C;
        if (mode == 0) return pix[k];
        if (r == 0 || r == R-1 || c == 0 || c == C-1) return (bord != 0) ? pix[k] : '0;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                w[n] = int'(pix[(r+dr)*C + c + dc]);
                n++;
            end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (w[j] > w[j+1]) begin
                    t = w[j]; w[j] = w[j+1]; w[j+1] = t;
                end
        case (mode)
            1:       return DW'(w[4]);
            2:       return DW'(w[0]);
            default: return DW'(w[8]);
        endcase
    endfunction

    task automatic set_const(input int v);
        for (int k = 0; k < N; k++) pix[k] = DW'(v);
    endtask

    task automatic set_ramp();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) pix[r*C + c] = DW'(10*r + c);
        pix[2*C + 2] = 8'd255;
    endtask

    task automatic set_rand();
        for (int k = 0; k < N; k++) pix[k] = DW'($urandom_range(0, 255));
    endtask

    task automatic begin_frame();
        out_cnt   = 0;
        busy_cnt  = 0;
        first_cyc = -1;
    endtask

    task automatic drive_frame(input int mode, input int bord, input int npix,
                               input bit gap, input bit ovf);
        for (int k = 0; k < npix; k++) begin
            @(posedge clk); #1;
            valid_i  = 1'b1;
            data_i   = pix[k];
            mode_i   = 2'(mode);
            border_i = bord[0];
            if (k == 6) acc6 = cyc;
            sb.push_back('{data: ref_out(k, mode, bord), last: (k == N-1)});
            if (gap) begin
                @(posedge clk); #1;
                valid_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        if (ovf) begin
            check("busy_at_pulse", int'(busy_o), 1);
            valid_i = 1'b1;
            data_i  = 8'hA5;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy_o) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs pending, required 0", sb.size());
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst     = 1'b0;
        valid_i = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_valid_o", int'(valid_o), 0);
            check("rst_last_o", int'(last_o), 0);
        end
        check("rst_data_o", int'(data_o), 0);
        check("rst_busy_o", int'(busy_o), 0);
        check("rst_overflow_o", int'(overflow_o), 0);
        sb.delete();
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        mode_i   = 2'd0;
        border_i = 1'b0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (busy_o) busy_cnt++;
                if (valid_o) begin
                    if (out_cnt == 0) first_cyc = cyc;
                    if (out_cnt < N) cap[out_cnt] = data_o;
                    out_cnt++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %0d, required no output", data_o);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("data_o", int'(data_o), int'(e.data));
                        check("last_o", int'(last_o), int'(e.last));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("init_valid_o", int'(valid_o), 0);
        check("init_data_o", int'(data_o), 0);
        check("init_last_o", int'(last_o), 0);
        check("init_busy_o", int'(busy_o), 0);
        check("init_overflow_o", int'(overflow_o), 0);
        rst = 1'b1;

        // Constant 50, median, zero border.
        set_const(50);
        begin_frame();
        drive_frame(1, 0, N, 1'b0, 1'b0);
        wait_drain();
        check("t1_count", out_cnt, N);
        check("t1_latency", first_cyc - acc6, 4);
        check("t1_busy_cycles", busy_cnt, C + 1);
        check("t1_border_0_0", int'(cap[0]), 0);
        check("t1_interior_1_1", int'(cap[6]), 50);
        check("t1_interior_2_2", int'(cap[12]), 50);
        check("t1_border_4_4", int'(cap[24]), 0);

        // Ramp with 255 centre, border pass-through, each rank mode.
        set_ramp();
        begin_frame();
        drive_frame(1, 1, N, 1'b0, 1'b0);
        wait_drain();
        check("t2_med_count", out_cnt, N);
        check("t2_med_2_2", int'(cap[12]), 23);
        check("t2_med_1_1", int'(cap[6]), 11);
        check("t2_med_border_0_3", int'(cap[3]), 3);

        begin_frame();
        drive_frame(2, 1, N, 1'b0, 1'b0);
        wait_drain();
        check("t2_min_2_2", int'(cap[12]), 11);
        check("t2_min_border_3_4", int'(cap[19]), 34);

        begin_frame();
        drive_frame(3, 1, N, 1'b0, 1'b0);
        wait_drain();
        check("t2_max_2_2", int'(cap[12]), 255);
        check("t2_max_1_1", int'(cap[6]), 255);
        check("t2_max_border_0_3", int'(cap[3]), 3);

        // Bypass of a random frame.
        set_rand();
        begin_frame();
        drive_frame(0, 0, N, 1'b0, 1'b0);
        wait_drain();
        check("t3_count", out_cnt, N);
        check("t3_busy_cycles", busy_cnt, C + 1);
        check("t3_first", int'(cap[0]), int'(pix[0]));
        check("t3_final", int'(cap[N-1]), int'(pix[N-1]));

        // Constant 50 with valid_i every other cycle.
        set_const(50);
        begin_frame();
        drive_frame(1, 0, N, 1'b1, 1'b0);
        wait_drain();
        check("t4_count", out_cnt, N);
        check("t4_interior_2_2", int'(cap[12]), 50);

        // Pulse during flush sets sticky overflow.
        begin_frame();
        drive_frame(1, 0, N, 1'b0, 1'b1);
        wait_drain();
        check("t5_overflow", int'(overflow_o), 1);
        check("t5_count", out_cnt, N);
        check("t5_interior_2_2", int'(cap[12]), 50);
        do_reset();

        // Reset in mid-frame, then a clean median frame.
        set_ramp();
        begin_frame();
        drive_frame(1, 1, 12, 1'b0, 1'b0);
        do_reset();
        begin_frame();
        drive_frame(1, 1, N, 1'b0, 1'b0);
        wait_drain();
        check("t6_count", out_cnt, N);
        check("t6_med_2_2", int'(cap[12]), 23);
        check("t6_overflow", int'(overflow_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
